// File: rtl/axi4_burst_sequencer.sv
// Sequences a stream transfer of N fixed-length INCR bursts through a 32-bit AXI4 master port.
// Optional mid-transfer abort is compiled in with `define AXI_BURST_SEQ_ABORT_EN.
module axi4_burst_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_BURST_LEN        = 256,
  parameter int C_NBURST_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef AXI_BURST_SEQ_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_NBURST_WIDTH-1:0]     cmd_nbursts,
  output logic                          busy,
  output logic                          done,
  output logic                          err,

  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,

  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,

  input  logic [31:0]                   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  localparam int BEAT_W = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_BURST_LEN - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES = C_M_AXI_ADDR_WIDTH'(C_BURST_LEN * 4);
  localparam logic [C_NBURST_WIDTH-1:0] ONE_BURST = C_NBURST_WIDTH'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;

  logic [2:0]                    state;
  logic                          dir;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [C_NBURST_WIDTH-1:0]     remaining;
  logic [BEAT_W-1:0]             beat;
  logic                          err_q;
  logic                          abort_req;

  logic in_wdata;
  logic in_rdata;
  logic addr_hs;
  logic w_hs;
  logic r_hs;
  logic last_burst;
  logic beat_at_last;

  assign in_wdata     = (state == S_DATA) &  dir;
  assign in_rdata     = (state == S_DATA) & ~dir;
  assign addr_hs      = (state == S_ADDR) & (dir ? M_AXI_AWREADY : M_AXI_ARREADY);
  assign w_hs         = in_wdata & s_axis_tvalid & M_AXI_WREADY;
  assign r_hs         = in_rdata & M_AXI_RVALID & m_axis_tready;
  assign last_burst   = (remaining == ONE_BURST);
  assign beat_at_last = (beat == LAST_BEAT);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_NEXT) & (last_burst | abort_req);
  assign err       = err_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWLEN   = 8'(C_BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'd2;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = (state == S_ADDR) & dir;

  assign M_AXI_WDATA   = s_axis_tdata;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WLAST   = in_wdata & beat_at_last;
  assign M_AXI_WVALID  = in_wdata & s_axis_tvalid;
  assign s_axis_tready = in_wdata & M_AXI_WREADY;
  assign M_AXI_BREADY  = (state == S_RESP);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARLEN   = 8'(C_BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'd2;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = (state == S_ADDR) & ~dir;

  assign M_AXI_RREADY  = in_rdata & m_axis_tready;
  assign m_axis_tvalid = in_rdata & M_AXI_RVALID;
  assign m_axis_tdata  = M_AXI_RDATA;
  // TLAST marks the end of the whole transfer, not of each burst.
  assign m_axis_tlast  = in_rdata & M_AXI_RLAST & last_burst;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dir       <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      beat      <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            dir       <= cmd_write;
            addr      <= cmd_addr;
            remaining <= (cmd_nbursts == '0) ? ONE_BURST : cmd_nbursts;
            err_q     <= 1'b0;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (addr_hs) begin
            beat  <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (dir) begin
            if (w_hs) begin
              beat <= beat + BEAT_W'(1);
              if (beat_at_last) state <= S_RESP;
            end
          end else if (r_hs) begin
            beat <= beat + BEAT_W'(1);
            // A short or overlong burst is flagged but still drained to RLAST.
            if (M_AXI_RLAST) begin
              if ((M_AXI_RRESP != 2'b00) || !beat_at_last) err_q <= 1'b1;
              state <= S_NEXT;
            end else if (beat_at_last) begin
              err_q <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          remaining <= remaining - ONE_BURST;
          addr      <= addr + BURST_BYTES;
          state     <= (last_burst | abort_req) ? S_IDLE : S_ADDR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_BURST_SEQ_ABORT_EN
  // Abort only takes effect at the next burst boundary; clears when a new command starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      abort_req <= 1'b0;
    end else if (state == S_IDLE) begin
      if (cmd_valid) abort_req <= 1'b0;
    end else if (abort) begin
      abort_req <= 1'b1;
    end
  end
`else
  assign abort_req = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_burst_sequencer.sv
// Randomized bench for axi4_burst_sequencer with a transaction-level reference model.
// Exercises the abort path when AXI_BURST_SEQ_ABORT_EN is defined.
module tb_axi4_burst_sequencer;
  localparam int AW  = 32;
  localparam int L   = 4;
  localparam int NBW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
`ifdef AXI_BURST_SEQ_ABORT_EN
  logic abort;
`endif
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [NBW-1:0] cmd_nbursts;
  logic busy, done, err;
  logic [0:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic awvalid, awready, arvalid, arready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic [31:0] s_tdata, m_tdata;
  logic s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;

  axi4_burst_sequencer #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_ID_WIDTH(1), .C_BURST_LEN(L), .C_NBURST_WIDTH(NBW)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef AXI_BURST_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_nbursts(cmd_nbursts),
    .busy(busy), .done(done), .err(err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Contents the memory model returns for a byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic roll(input int prob);
    return (int'($urandom_range(99)) < prob);
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_nbursts = '0;
    awready = 0; arready = 0; wready = 0; bresp = 2'b00; bvalid = 0;
    rdata = '0; rresp = 2'b00; rlast = 0; rvalid = 0;
    s_tdata = '0; s_tvalid = 0; m_tready = 0;
`ifdef AXI_BURST_SEQ_ABORT_EN
    abort = 0;
`endif
  endtask

  task automatic check_idle(input string name);
    check_val({name, ".cmd_ready"}, cmd_ready, 1);
    check_val({name, ".busy"}, busy, 0);
    check_val({name, ".done"}, done, 0);
    check_val({name, ".err"}, err, 0);
    check_val({name, ".valids"}, {awvalid, arvalid, wvalid, bready, rready, s_tready, m_tvalid}, 0);
    check_val({name, ".awaddr"}, awaddr, 0);
    check_val({name, ".araddr"}, araddr, 0);
  endtask

  task automatic run_cmd(input string name, input bit wr, input logic [31:0] base, input int nb,
                         input int bad_b, input int end_b, input int end_at, input int prob,
                         input int abort_b, input int rst_beat);
    int nb_eff, n_exp, bursts, beat, budget, src_idx, last_k;
    bit active, b_pend, fin, hit_rst, abort_sent, err_exp;
    logic [31:0] cur_a;
    logic [31:0] addr_seen[$];
    logic [31:0] src[$];
    logic [31:0] wr_data[$];
    logic [31:0] wr_addr[$];
    bit wr_last[$];
    logic [31:0] rd_data[$];
    bit rd_last[$];
    logic [31:0] exp_d[$];
    bit exp_l[$];

    nb_eff = (nb == 0) ? 1 : nb;
    bursts = 0; beat = 0; budget = 0; src_idx = 0; cur_a = '0;
    active = 0; b_pend = 0; fin = 0; hit_rst = 0; abort_sent = 0;

    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = base; cmd_nbursts = NBW'(nb);
    #1 check_val({name, ".accept_ready"}, cmd_ready, 1);

    while (!fin && !hit_rst && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (budget == 1) begin
        cmd_valid = 0;
        check_val({name, ".err_cleared"}, err, 0);
        check_val({name, ".busy"}, busy, 1);
      end
      awready = roll(prob); arready = roll(prob); wready = roll(prob);
      if (src_idx == src.size()) src.push_back($urandom);
      s_tdata  = src[src_idx];
      s_tvalid = roll(prob);
      m_tready = roll(prob);
      rvalid = active && !wr && roll(prob);
      rdata  = mem_word(cur_a + 32'(4 * beat));
      rlast  = (beat == ((bursts - 1 == end_b) ? end_at : L - 1));
      rresp  = 2'b00;
      bvalid = b_pend && roll(prob);
      bresp  = (bursts - 1 == bad_b) ? 2'b10 : 2'b00;
`ifdef AXI_BURST_SEQ_ABORT_EN
      abort = 0;
      if (!abort_sent && active && (bursts - 1 == abort_b)) begin
        abort = 1; abort_sent = 1;
      end
`endif
      #1;
      if (awvalid && awready) begin
        addr_seen.push_back(awaddr); cur_a = awaddr; active = 1; beat = 0; bursts++;
      end
      if (arvalid && arready) begin
        addr_seen.push_back(araddr); cur_a = araddr; active = 1; beat = 0; bursts++;
      end
      if (s_tvalid && s_tready) src_idx++;
      if (wvalid && wready) begin
        wr_data.push_back(wdata);
        wr_addr.push_back(cur_a + 32'(4 * beat));
        wr_last.push_back(wlast);
        if (beat == L - 1) begin active = 0; b_pend = 1; end
        beat++;
        if (rst_beat >= 0 && int'(wr_data.size()) == rst_beat) hit_rst = 1;
      end
      if (bvalid && bready) b_pend = 0;
      if (rvalid && rready) begin
        if (rlast) active = 0;
        beat++;
      end
      if (m_tvalid && m_tready) begin
        rd_data.push_back(m_tdata);
        rd_last.push_back(m_tlast);
      end
      if (done) fin = 1;
    end

    if (hit_rst) begin
      idle_inputs();
      reset = 1;
      @(negedge clk);
      reset = 0;
      #1 check_idle({name, ".after_reset"});
      return;
    end
    check_val({name, ".finished"}, fin, 1);

    n_exp = nb_eff;
`ifdef AXI_BURST_SEQ_ABORT_EN
    if (abort_b >= 0 && abort_b < nb_eff - 1) n_exp = abort_b + 1;
`endif
    check_val({name, ".n_addr"}, addr_seen.size(), n_exp);
    for (int i = 0; i < addr_seen.size() && i < n_exp; i++)
      check_val($sformatf("%s.addr%0d", name, i), addr_seen[i], base + 32'(i * L * 4));

    if (wr) begin
      err_exp = (bad_b >= 0 && bad_b < n_exp);
      check_val({name, ".n_wbeats"}, wr_data.size(), n_exp * L);
      check_val({name, ".src_taken"}, src_idx, n_exp * L);
      for (int i = 0; i < wr_data.size() && i < n_exp * L; i++) begin
        check_val($sformatf("%s.wdata%0d", name, i), wr_data[i], src[i]);
        check_val($sformatf("%s.waddr%0d", name, i), wr_addr[i], base + 32'(4 * i));
        check_val($sformatf("%s.wlast%0d", name, i), wr_last[i], (i % L) == L - 1);
      end
    end else begin
      err_exp = (end_b >= 0 && end_b < n_exp && end_at != L - 1);
      for (int b = 0; b < n_exp; b++) begin
        last_k = (b == end_b) ? end_at : L - 1;
        for (int k = 0; k <= last_k; k++) begin
          exp_d.push_back(mem_word(base + 32'(b * L * 4 + 4 * k)));
          exp_l.push_back((b == n_exp - 1) && (k == last_k) && (n_exp == nb_eff));
        end
      end
      check_val({name, ".n_rbeats"}, rd_data.size(), exp_d.size());
      for (int i = 0; i < rd_data.size() && i < exp_d.size(); i++) begin
        check_val($sformatf("%s.rdata%0d", name, i), rd_data[i], exp_d[i]);
        check_val($sformatf("%s.tlast%0d", name, i), rd_last[i], exp_l[i]);
      end
    end

    @(negedge clk);
    #1;
    check_val({name, ".err"}, err, err_exp);
    check_val({name, ".done_one_cycle"}, done, 0);
    check_val({name, ".ready_after"}, cmd_ready, 1);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #1 check_idle("reset");
    check_val("reset.awlen", awlen, L - 1);
    check_val("reset.axsize", {awsize, arsize, awburst, arburst}, {3'd2, 3'd2, 2'b01, 2'b01});
    check_val("reset.ids_strb", {awid, arid, wstrb}, 6'b00_1111);

    run_cmd("wr_basic",  1'b1, 32'h0000_1000, 2, -1, -1, 0, 100, -1, -1);
    run_cmd("rd_basic",  1'b0, 32'h0000_2000, 3, -1, -1, 0, 50,  -1, -1);
    run_cmd("wr_bresp",  1'b1, 32'h0000_3000, 2, 0,  -1, 0, 70,  -1, -1);
    run_cmd("rd_clear",  1'b0, 32'h0000_4000, 1, -1, -1, 0, 80,  -1, -1);
    run_cmd("rd_early",  1'b0, 32'h0000_5000, 2, -1, 0,  2, 70,  -1, -1);
    run_cmd("rd_late",   1'b0, 32'h0000_6000, 2, -1, 1,  5, 60,  -1, -1);
    run_cmd("rd_lastsh", 1'b0, 32'h0000_6100, 2, -1, 1,  1, 90,  -1, -1);
    run_cmd("wr_rst",    1'b1, 32'h0000_7000, 2, -1, -1, 0, 100, -1, 2);
    run_cmd("wr_postrst",1'b1, 32'h0000_7100, 1, -1, -1, 0, 60,  -1, -1);
    run_cmd("rd_zero",   1'b0, 32'h0000_8000, 0, -1, -1, 0, 100, -1, -1);
    run_cmd("wr_wrap",   1'b1, 32'hFFFF_FFF0, 2, -1, -1, 0, 75,  -1, -1);
`ifdef AXI_BURST_SEQ_ABORT_EN
    run_cmd("rd_abort",  1'b0, 32'h0000_9000, 5, -1, -1, 0, 80,  1, -1);
    run_cmd("wr_abort",  1'b1, 32'h0000_A000, 3, -1, -1, 0, 80,  0, -1);
`endif
    for (int t = 0; t < 8; t++) begin
      int nb, bb, eb;
      bit wr;
      nb = int'($urandom_range(1, 3));
      wr = 1'($urandom_range(1));
      bb = int'($urandom_range(0, 3)) - 1;
      eb = int'($urandom_range(0, 3)) - 1;
      run_cmd($sformatf("rand%0d", t), wr, $urandom & 32'hFFFF_FFF0, nb, bb, eb,
              int'($urandom_range(0, 6)), int'($urandom_range(30, 100)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_burst_sequencer.md
Name: axi4_burst_sequencer

Overview:
- Command-driven controller that sequences fixed-length INCR bursts through the 32-bit slave port of the 32-to-64-bit AXI4 width converter.
- Splits one stream transfer of N bursts into consecutive AR or AW bursts, one outstanding at a time.
- Write direction: gates an AXI4-Stream source onto the W channel and generates WLAST.
- Read direction: forwards R beats to an AXI4-Stream sink with TLAST on the final beat of the transfer.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_ID_WIDTH, 1, ID width; AWID/ARID driven 0.
- C_BURST_LEN, 256, 32-bit beats per burst; power of two, ≤256; must equal the converter's C_S_AXI_BURST_LEN.
- C_NBURST_WIDTH, 16, width of the burst-count field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = stream-to-memory, 0 = memory-to-stream.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte base address; C_BURST_LEN*4-aligned.
- cmd_nbursts  in  C_NBURST_WIDTH  burst count; 0 is illegal and is treated as 1.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse at transfer end.
- err  out  1  sticky error flag; cleared on next command accept.
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  per AXI4  AWLEN=C_BURST_LEN-1, AWSIZE=2, AWBURST=1.
- M_AXI_AWREADY  in  1  AW handshake.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  byte strobes.
- M_AXI_WLAST  out  1  last write beat of burst.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  W handshake.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  per AXI4  same constants as AW.
- M_AXI_ARREADY  in  1  AR handshake.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last read beat of burst.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.
- s_axis_tdata  in  32  write stream data.
- s_axis_tvalid  in  1  write stream valid.
- s_axis_tready  out  1  write stream ready.
- m_axis_tdata  out  32  read stream data.
- m_axis_tvalid  out  1  read stream valid.
- m_axis_tready  in  1  read stream ready.
- m_axis_tlast  out  1  last beat of read transfer.

Behaviour:
- Reset values: state IDLE, all counters 0, AWVALID/ARVALID/WVALID/BREADY/RREADY/done/err/busy = 0, cmd_ready = 1, AWADDR/ARADDR = 0. Reset mid-transfer abandons immediately; the converter is reset on the same reset.
- Command accept: cmd_valid & cmd_ready. Latch dir, addr, remaining = max(cmd_nbursts,1); clear err; go to ADDR next cycle.
- ADDR: assert AWVALID (write) or ARVALID (read) with the latched address. Hold VALID and address stable until READY. On handshake: beat counter = 0, go to DATA.
- DATA, write:
  - WVALID = s_axis_tvalid; s_axis_tready = M_AXI_WREADY; WDATA = s_axis_tdata; WSTRB = 4'hF.
  - WLAST = (beat == C_BURST_LEN-1).
  - Each W handshake increments beat. Handshake with WLAST goes to RESP.
- RESP: BREADY = 1. On BVALID: BRESP != 0 sets err; go to NEXT.
- DATA, read:
  - m_axis_tvalid = RVALID; RREADY = m_axis_tready; m_axis_tdata = RDATA.
  - m_axis_tlast = RLAST & (remaining == 1).
  - Each R handshake increments beat.
  - Handshake with RLAST: RRESP != 0 or beat != C_BURST_LEN-1 sets err; go to NEXT.
  - Handshake at beat == C_BURST_LEN-1 without RLAST sets err; keep accepting until RLAST.
- NEXT (one cycle):
  - remaining -= 1, addr += C_BURST_LEN*4 (modulo 2^ADDR_WIDTH).
  - remaining was 1: pulse done, go to IDLE.
  - Otherwise: go to ADDR.
- Outside DATA: s_axis_tready, m_axis_tvalid, WVALID and RREADY are 0.
- Minimum overhead per burst: 1 cycle in ADDR (if READY is already high) + 1 NEXT cycle, plus B wait for writes.
- A new command can be accepted on the cycle after done.

Optional Feature:
- Macro AXI_BURST_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit), sampled in any non-IDLE state and latched as abort_req.
  - The current burst always completes its full protocol.
  - In NEXT, abort_req forces the exit to IDLE with a done pulse; the remaining bursts are never issued.
  - m_axis_tlast is still only asserted on a natural final beat.
  - abort_req clears on command accept.
- Not defined: no abort port; every transfer runs to completion.

Test Plan:
- Write, addr 0x1000, nbursts 2, C_BURST_LEN 4, always-ready slave -> AW at 0x1000 then 0x1010; WLAST on beats 3 and 7; done pulse after the 2nd BVALID; err = 0.
- Read, addr 0x2000, nbursts 3, m_axis_tready toggling 50% -> AR at 0x2000/0x2010/0x2020; 12 beats in order; m_axis_tlast only on beat 11; no beats dropped.
- Write with BRESP = 2'b10 on burst 1 of 2 -> err = 1 stays set; second burst still issued; done pulses; next command accept clears err.
- Read with RLAST asserted early on beat 2 -> err = 1; sequencer advances to the next burst.
- Assert reset in DATA mid-burst -> next cycle state IDLE, cmd_ready = 1, all VALID/READY outputs 0; a new command completes correctly.
- With AXI_BURST_SEQ_ABORT_EN: nbursts 5, abort during burst 1 -> exactly 2 ARs issued; done pulses after burst 1 completes.
